// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: a WIDTH-bit carry-ripple adder cut into CHUNK-bit
// slices, one slice per stage, with valid/ready handshakes on both sides.
module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int STAGES = WIDTH / CHUNK;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_badParam
            $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic             w_en;
    logic [WIDTH-1:0] w_aIn  [STAGES];
    logic [WIDTH-1:0] w_bIn  [STAGES];
    logic [WIDTH-1:0] w_sIn  [STAGES];
    logic [WIDTH-1:0] w_sOut [STAGES];
    logic             w_cIn  [STAGES];
    logic             w_vIn  [STAGES];
    logic             w_cOut [STAGES];
    logic [CHUNK:0]   w_part [STAGES];
    logic             w_ovf;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    // One enable for the whole pipe: it only moves when the output slot frees up.
    assign w_en    = !r_v[STAGES-1] || ready_i;
    assign ready_o = w_en;

    // Each stage sees the operands still waiting in the skew registers and the
    // sums already finished in the deskew registers; it fills in only its own chunk.
    always_comb begin
        w_aIn[0] = a_i;
        w_bIn[0] = b_i ^ {WIDTH{sub_i}};
        w_sIn[0] = '0;
        w_cIn[0] = sub_i | cin_i;
        w_vIn[0] = valid_i;
        for (int k = 1; k < STAGES; k++) begin
            w_aIn[k] = r_a[k-1];
            w_bIn[k] = r_b[k-1];
            w_sIn[k] = r_s[k-1];
            w_cIn[k] = r_c[k-1];
            w_vIn[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_part[k] = {1'b0, w_aIn[k][k*CHUNK +: CHUNK]}
                      + {1'b0, w_bIn[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, w_cIn[k]};
            w_sOut[k] = w_sIn[k];
            w_sOut[k][k*CHUNK +: CHUNK] = w_part[k][CHUNK-1:0];
            w_cOut[k] = w_part[k][CHUNK];
        end
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        w_ovf = w_aIn[STAGES-1][WIDTH-1] ^ w_bIn[STAGES-1][WIDTH-1]
              ^ w_sOut[STAGES-1][WIDTH-1] ^ w_cOut[STAGES-1];
    end

    // Data registers load only behind a valid token so a bubble leaves the
    // last result sitting on the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_vIn[k];
                if (w_vIn[k]) begin
                    r_a[k] <= w_aIn[k];
                    r_b[k] <= w_bIn[k];
                    r_s[k] <= w_sOut[k];
                    r_c[k] <= w_cOut[k];
                end
            end
            if (w_vIn[STAGES-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign valid_o = r_v[STAGES-1];
    assign sum_o   = r_s[STAGES-1];
    assign cout_o  = r_c[STAGES-1];
    assign ovf_o   = r_ovf;

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined carry-ripple add/subtract unit. Successor to the fixed 4-bit ripple adder.
- The WIDTH-bit operation is split into CHUNK-bit ripple slices, one slice per pipeline stage. The carry is registered between stages, and operands and results are skewed/deskewed through registers.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Supports per-transaction add/subtract selection and produces carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits summed per pipeline stage (ripple length per stage).
- STAGES, WIDTH/CHUNK, derived. Number of pipeline stages. Not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  input transaction valid
- ready_o  output  1  unit can accept an input this cycle
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in; used only when sub_i=0
- sub_i  input  1  1 = A-B (B inverted, carry-in forced 1); 0 = A+B+cin_i
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts the result this cycle
- sum_o  output  WIDTH  result
- cout_o  output  1  carry out of the MSB (for subtract: 1 = no borrow)
- ovf_o  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset:
  - Asynchronous, active when rst_ni=0.
  - Clears every stage valid bit, sum_o, cout_o and ovf_o to 0.
  - ready_o is 1 once out of reset with the pipeline empty.
  - Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Global enable: en = !valid_o || ready_i.
  - ready_o = en (combinational).
  - When en=0, every stage register, including skew registers, holds its value.
- Input handshake: a transfer occurs when valid_i && ready_o.
  - Stage 0 captures chunk 0 of A and B', where B' = b_i XOR {WIDTH{sub_i}}.
  - Stage 0 carry-in is sub_i ? 1 : cin_i.
  - The upper chunks of A and B' enter the skew registers.
- Stage k (0..STAGES-1):
  - Ripple-adds chunk k using the carry registered from stage k-1 (stage 0 uses the effective carry-in).
  - Registers the chunk-k sum, the carry-out and the valid bit.
  - Carries lower-chunk sums forward in deskew registers.
  - Stage valid = previous valid when en; a bubble (no transfer) propagates as valid=0.
- Output:
  - The last stage drives valid_o, sum_o, cout_o and ovf_o directly from registers.
  - ovf_o is computed in the last stage from the MSB carry-in and carry-out.
- Latency and throughput:
  - A transfer at cycle t with no stall gives valid_o=1 at cycle t+STAGES.
  - Throughput is 1 result per cycle.
  - Bubbles are not compressed: an empty stage still occupies its slot.
- Backpressure:
  - When valid_o=1 and ready_i=0, ready_o=0 on the same cycle and the output holds stable until accepted.
  - The same-cycle accept-and-push (valid_o && ready_i && valid_i) is allowed; the pipeline advances.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; cout_o is the carry-out beyond bit WIDTH-1.
  - With CHUNK=WIDTH, STAGES=1 and the unit degenerates to a single registered adder with latency 1.
- Data outputs are don't-care when valid_o=0, but are held at their last value; after reset they are 0.

Test Plan (WIDTH=32, CHUNK=4, STAGES=8 unless noted):
- Basic add: A=0x0000_0001, B=0x0000_0002, cin=0, sub=0, issued at t0 → at t0+8 valid_o=1, sum=0x0000_0003, cout=0, ovf=0.
- Full carry ripple across every stage: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, ovf=0. Then A=0x7FFF_FFFF, B=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Subtract: A=5, B=7, sub=1 → sum=0xFFFF_FFFE, cout=0, ovf=0. Then A=0x8000_0000, B=1, sub=1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
- Streaming and backpressure:
  - Issue 20 back-to-back random transactions.
  - Hold ready_i=0 for 5 cycles mid-stream; ready_o drops on the same cycle and sum_o stays stable.
  - All 20 results must match a reference model, in order, with no loss or duplication.
- Reset mid-operation: deassert rst_ni with 3 transactions in flight → valid_o=0 and sum_o=0 immediately. After release, no stale result appears and the next transaction completes in 8 cycles.
- Parameter sweep: WIDTH=8 with CHUNK=8 (latency 1), WIDTH=16 with CHUNK=2 (latency 8), and WIDTH=64 with CHUNK=16 (latency 4), each with 1000 random add/sub vectors checked against a model.
